data_memory: RTL and testbench
==============================

# data_memory

Word-addressed 32-bit data memory for the single-cycle processor datapath. It sits behind the load/store stage. It decodes a fixed address window and performs synchronous writes and combinational (asynchronous) reads. Accesses outside the window are ignored on write, read as zero, and flagged.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h4700_0000: byte base address of the window; must be aligned to the window size.
- `DEPTH_LOG2`, default 8: log2 of the word count (256 words, 1 KiB window).

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset; synchronous and active-high.
- `A`, input, 32: byte address.
- `WD`, input, 32: write data.
- `WE`, input, 1: write enable, active-high.
- `RD`, output, 32: read data, combinational.
- `ERR`, output, 1: combinational out-of-range flag.

## Operation
- Storage is `2**DEPTH_LOG2` words of 32 bits each.
- In-window test: `A[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]`.
- Word index is `A[DEPTH_LOG2+1:2]`. `A[1:0]` is ignored unless `DM_ALIGN_CHECK_EN` is defined (see Configuration).
- Read, in window: `RD` = mem[index].
- Read, out of window: `RD` = 32'h0 and `ERR` = 1.
- Otherwise `ERR` = 0.
- Write: on a rising edge with `WE`=1, `rst`=0 and an in-window address, mem[index] <= `WD`.
- Out-of-window writes are dropped and no memory word changes.
- Reset: on a rising edge with `rst`=1, every word is cleared to 32'h0.
- Reset has priority over a simultaneous write; that write is lost.
- No partial (byte or halfword) writes. Every write is a full 32-bit word.

## Timing
- Read latency is 0 cycles. `RD` and `ERR` follow `A` combinationally, with no dependence on `clk` or `WE`.
- Write latency is 1 edge. The written value appears on `RD` right after the rising edge that commits it.
- Read during write to the same word: before the edge `RD` shows the old value; after the edge it shows `WD`.
- Reset takes effect at the edge. Until that edge, memory contents and `RD` keep their old values.
- After the reset edge, `RD` = 0 for every in-window address. `ERR` depends only on `A` and is unaffected by reset.
- Reset asserted in the middle of a sequence of writes: all earlier writes are erased.
- Window boundaries, with defaults:
  - 0x4700_0000 maps to word 0.
  - 0x4700_03FC maps to word 255.
  - 0x4700_0400 and 0x46FF_FFFC are out of window.

## Configuration
- `DM_ALIGN_CHECK_EN` defined:
  - An access with `A[1:0]` != 0 is treated as out of window.
  - `ERR` = 1, `RD` = 0, and a write is dropped.
- Undefined (default): `A[1:0]` is ignored, so 0x4700_0011 accesses word 4.

## Test plan
1. Reset, then write 0x4700_0000 / 0x1111_1111 with `WE`=1 for one edge, then set `WE`=0 -> `RD` = 0x1111_1111, `ERR`=0.
2. Write 0x4700_0011 / 0x1111_1111, then read 0x4700_0010 -> `RD` = 0x1111_1111 (word 4). With `DM_ALIGN_CHECK_EN` defined: the write is dropped, `ERR`=1, and reading 0x4700_0010 returns 0.
3. Write 0x1000_0000, 0x0000_0101 and 0x1000_0101, each with `WD` 0x1111_1111 and `WE`=1 -> `ERR`=1 and `RD`=0 on each. Reading all 256 in-window words afterwards shows no change.
4. Write word 255 (0x4700_03FC) with 0xDEAD_BEEF -> reading 0x4700_03FC returns 0xDEAD_BEEF. Reading 0x4700_0400 gives `ERR`=1, `RD`=0.
5. Same-cycle checks:
   - Hold `A`=0x4700_0008, `WD`=0xA5A5_A5A5, `WE`=1 -> `RD` shows the old value before the edge and 0xA5A5_A5A5 after it.
   - Then hold `rst`=1 and `WE`=1 together with `WD`=0x5A5A_5A5A -> after the edge, word 2 reads 0.
6. Fill every word with its index, then assert `rst` for one edge -> all 256 words read 0 afterwards.

Source files
------------

// File: rtl/data_memory.sv
// Word-addressed 32-bit data memory: synchronous write, combinational read, out-of-window flag.
// Optional DM_ALIGN_CHECK_EN treats misaligned addresses as out of window; no backpressure, 0-cycle read, 1-edge write.
module data_memory #(
  parameter logic [31:0] BASE_ADDR  = 32'h4700_0000,
  parameter int          DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        ERR
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic                  in_window;
  logic [DEPTH_LOG2-1:0] word_idx;

  assign word_idx = A[DEPTH_LOG2+1:2];

`ifdef DM_ALIGN_CHECK_EN
  assign in_window = (A[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]) && (A[1:0] == 2'b00);
`else
  // Byte offset within the word has no meaning for full-word accesses.
  logic unused_byte_offset;
  assign unused_byte_offset = ^A[1:0];
  assign in_window = (A[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
`endif

  assign RD  = in_window ? mem[word_idx] : 32'h0;
  assign ERR = ~in_window;

  // Reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (WE && in_window) begin
      mem[word_idx] <= WD;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: reference memory model feeds a scoreboard queue of expected RD/ERR.
module tb_data_memory;

  localparam logic [31:0] BASE = 32'h4700_0000;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        ERR;

  logic [31:0] model [256];
  exp_t        sb [$];
  int          checks;
  int          errors;

  data_memory dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .WD  (WD),
    .WE  (WE),
    .RD  (RD),
    .ERR (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  function automatic logic in_win(input logic [31:0] a);
    logic ok;
    ok = (a[31:10] == BASE[31:10]);
`ifdef DM_ALIGN_CHECK_EN
    ok = ok && (a[1:0] == 2'b00);
`endif
    return ok;
  endfunction

  function automatic exp_t model_rd(input logic [31:0] a);
    exp_t e;
    if (in_win(a)) begin
      e.rd  = model[a[9:2]];
      e.err = 1'b0;
    end else begin
      e.rd  = 32'h0;
      e.err = 1'b1;
    end
    return e;
  endfunction

  // Drive an address at the falling edge, queue its expected output, let it settle.
  task automatic apply_addr(input logic [31:0] a);
    @(negedge clk);
    A = a;
    sb.push_back(model_rd(a));
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    A = a; WD = d; WE = 1'b1;
    @(posedge clk);
    if (!rst && in_win(a)) model[a[9:2]] = d;
    #1;
    WE = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply_addr(BASE + 32'(i * 100 * 4) + 32'd4);
      e = sb.pop_front(); checks++;
      if ({RD, ERR} !== e) begin
        errors++;
        $display("FAIL reset_state[%0d]: got RD=%h ERR=%b, required RD=%h ERR=%b", i, RD, ERR, e.rd, e.err);
      end
    end
  endtask

  task automatic test_basic_write();
    exp_t e;
    do_write(BASE, 32'h1111_1111);
    apply_addr(BASE);
    e = sb.pop_front(); checks++;
    if ({RD, ERR} !== e || e.rd !== 32'h1111_1111) begin
      errors++;
      $display("FAIL basic_write: got RD=%h ERR=%b, required RD=%h ERR=%b", RD, ERR, e.rd, e.err);
    end
  endtask

  task automatic test_unaligned();
    exp_t e;
    @(negedge clk);
    A = BASE + 32'h11; WD = 32'h1111_1111; WE = 1'b1;
    sb.push_back(model_rd(A));
    #1;
    e = sb.pop_front(); checks++;
    if (ERR !== e.err) begin
      errors++;
      $display("FAIL unaligned_err: got ERR=%b, required ERR=%b", ERR, e.err);
    end
    @(posedge clk);
    if (in_win(A)) model[A[9:2]] = WD;
    #1;
    WE = 1'b0;
    apply_addr(BASE + 32'h10);
    e = sb.pop_front(); checks++;
    if ({RD, ERR} !== e) begin
      errors++;
      $display("FAIL unaligned_read: got RD=%h ERR=%b, required RD=%h ERR=%b", RD, ERR, e.rd, e.err);
    end
  endtask

  task automatic test_out_of_window();
    exp_t e;
    logic [31:0] addrs [3];
    int bad;
    addrs[0] = 32'h1000_0000; addrs[1] = 32'h0000_0101; addrs[2] = 32'h1000_0101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      A = addrs[k]; WD = 32'h1111_1111; WE = 1'b1;
      sb.push_back(model_rd(A));
      #1;
      e = sb.pop_front(); checks++;
      if ({RD, ERR} !== e || ERR !== 1'b1) begin
        errors++;
        $display("FAIL oow_write[%0d]: got RD=%h ERR=%b, required RD=%h ERR=%b", k, RD, ERR, e.rd, e.err);
      end
      @(posedge clk);
      #1;
      WE = 1'b0;
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      apply_addr(BASE + 32'(i * 4));
      e = sb.pop_front();
      if ({RD, ERR} !== e) begin
        if (bad == 0) $display("FAIL oow_nochange word %0d: got RD=%h ERR=%b, required RD=%h ERR=%b", i, RD, ERR, e.rd, e.err);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic test_boundary();
    exp_t e;
    do_write(BASE + 32'h3FC, 32'hDEAD_BEEF);
    apply_addr(BASE + 32'h3FC);
    e = sb.pop_front(); checks++;
    if ({RD, ERR} !== e || RD !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL top_word: got RD=%h ERR=%b, required RD=%h ERR=%b", RD, ERR, e.rd, e.err);
    end
    apply_addr(BASE + 32'h400);
    e = sb.pop_front(); checks++;
    if ({RD, ERR} !== e) begin
      errors++;
      $display("FAIL above_window: got RD=%h ERR=%b, required RD=%h ERR=%b", RD, ERR, e.rd, e.err);
    end
    apply_addr(32'h46FF_FFFC);
    e = sb.pop_front(); checks++;
    if ({RD, ERR} !== e) begin
      errors++;
      $display("FAIL below_window: got RD=%h ERR=%b, required RD=%h ERR=%b", RD, ERR, e.rd, e.err);
    end
    apply_addr(BASE);
    e = sb.pop_front(); checks++;
    if ({RD, ERR} !== e) begin
      errors++;
      $display("FAIL word0: got RD=%h ERR=%b, required RD=%h ERR=%b", RD, ERR, e.rd, e.err);
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    do_write(BASE + 32'h8, 32'h0BAD_F00D);
    @(negedge clk);
    A = BASE + 32'h8; WD = 32'hA5A5_A5A5; WE = 1'b1;
    sb.push_back(model_rd(A));
    #1;
    e = sb.pop_front(); checks++;
    if ({RD, ERR} !== e) begin
      errors++;
      $display("FAIL rdw_before: got RD=%h, required RD=%h", RD, e.rd);
    end
    @(posedge clk);
    model[2] = 32'hA5A5_A5A5;
    sb.push_back(model_rd(A));
    #1;
    e = sb.pop_front(); checks++;
    if ({RD, ERR} !== e) begin
      errors++;
      $display("FAIL rdw_after: got RD=%h, required RD=%h", RD, e.rd);
    end
    @(negedge clk);
    rst = 1'b1; WD = 32'h5A5A_5A5A;
    sb.push_back(model_rd(A));
    #1;
    e = sb.pop_front(); checks++;
    if ({RD, ERR} !== e) begin
      errors++;
      $display("FAIL rst_before_edge: got RD=%h, required RD=%h", RD, e.rd);
    end
    @(posedge clk);
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    #1;
    rst = 1'b0; WE = 1'b0;
    apply_addr(BASE + 32'h8);
    e = sb.pop_front(); checks++;
    if ({RD, ERR} !== e) begin
      errors++;
      $display("FAIL rst_beats_write: got RD=%h, required RD=%h", RD, e.rd);
    end
  endtask

  task automatic test_fill_and_reset();
    exp_t e;
    int bad;
    for (int i = 0; i < 256; i++) do_write(BASE + 32'(i * 4), 32'(i));
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      apply_addr(BASE + 32'(i * 4));
      e = sb.pop_front();
      if ({RD, ERR} !== e) begin
        if (bad == 0) $display("FAIL fill word %0d: got RD=%h, required RD=%h", i, RD, e.rd);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    do_reset();
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      apply_addr(BASE + 32'(i * 4));
      e = sb.pop_front();
      if ({RD, ERR} !== e || RD !== 32'h0) begin
        if (bad == 0) $display("FAIL clear word %0d: got RD=%h, required RD=%h", i, RD, e.rd);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; A = BASE; WD = 32'h0; WE = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    test_reset();
    test_basic_write();
    test_unaligned();
    test_out_of_window();
    test_boundary();
    test_same_cycle();
    test_fill_and_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
